// File: rtl/ysyx_22050598_ifu_fetch_if.sv
// rtl/ysyx_22050598_ifu_fetch_if.sv - IFU memory, redirect and decode-side handshake bundle
interface ysyx_22050598_ifu_fetch_if;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [63:0] mem_req_addr_o;
   logic        mem_resp_valid_i;
   logic        mem_resp_ready_o;
   logic [63:0] mem_resp_data_i;
   logic        redirect_valid_i;
   logic [63:0] redirect_pc_i;
   logic        if_valid_o;
   logic        id_ready_i;
   logic [31:0] if_inst_o;
   logic [63:0] if_pc_o;
   logic        if_misalign_o;

   modport master (
      output mem_req_valid_o, mem_req_addr_o, mem_resp_ready_o,
      output if_valid_o, if_inst_o, if_pc_o, if_misalign_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      input  redirect_valid_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  mem_req_valid_o, mem_req_addr_o, mem_resp_ready_o,
      input  if_valid_o, if_inst_o, if_pc_o, if_misalign_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      output redirect_valid_i, redirect_pc_i, id_ready_i
   );
endinterface

// File: rtl/ysyx_22050598_ifu_fetch.sv
// rtl/ysyx_22050598_ifu_fetch.sv - instruction fetch unit, one outstanding 64-bit read
// Optional misaligned-PC trap: define YSYX_22050598_IFU_MISALIGN_CHECK_EN.
module ysyx_22050598_ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          BUS_W    = 64
) (
   input logic                        clk,
   input logic                        rst,
   ysyx_22050598_ifu_fetch_if.master  bus
);
   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

   state_t      r_state, w_state_n;
   logic [63:0] r_pc, w_pc_n;
   logic        r_drop, w_drop_n;
   logic [31:0] r_inst, w_inst_n;
   logic [63:0] r_if_pc, w_if_pc_n;
   logic        r_misalign, w_misalign_n;
   logic [BUS_W-1:0] w_data;
   logic        w_misaligned;
   logic        w_req_fire;

`ifdef YSYX_22050598_IFU_MISALIGN_CHECK_EN
   assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_data               = bus.mem_resp_data_i;
   assign bus.mem_req_valid_o  = (r_state == S_REQ) && !w_misaligned;
   assign bus.mem_req_addr_o   = {r_pc[63:3], 3'b000};
   assign bus.mem_resp_ready_o = (r_state == S_WAIT);
   assign bus.if_valid_o       = (r_state == S_HOLD);
   assign bus.if_inst_o        = r_inst;
   assign bus.if_pc_o          = r_if_pc;
   assign bus.if_misalign_o    = r_misalign;
   assign w_req_fire           = bus.mem_req_valid_o && bus.mem_req_ready_i;

   always_comb begin
      w_state_n    = r_state;
      w_pc_n       = r_pc;
      w_drop_n     = r_drop;
      w_inst_n     = r_inst;
      w_if_pc_n    = r_if_pc;
      w_misalign_n = r_misalign;
      case (r_state)
         S_REQ: begin
            if (bus.redirect_valid_i) begin
               w_pc_n = bus.redirect_pc_i;
               // request already accepted: its response belongs to the old pc
               if (w_req_fire) begin
                  w_state_n = S_WAIT;
                  w_drop_n  = 1'b1;
               end
            end else if (w_misaligned) begin
               w_state_n    = S_HOLD;
               w_inst_n     = 32'h0000_0013;
               w_if_pc_n    = r_pc;
               w_misalign_n = 1'b1;
            end else if (w_req_fire) begin
               w_state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.redirect_valid_i) begin
               w_pc_n = bus.redirect_pc_i;
               if (bus.mem_resp_valid_i) begin
                  w_state_n = S_REQ;
                  w_drop_n  = 1'b0;
               end else begin
                  w_drop_n  = 1'b1;
               end
            end else if (bus.mem_resp_valid_i) begin
               if (r_drop) begin
                  w_drop_n  = 1'b0;
                  w_state_n = S_REQ;
               end else begin
                  w_inst_n     = r_pc[2] ? w_data[63:32] : w_data[31:0];
                  w_if_pc_n    = r_pc;
                  w_misalign_n = 1'b0;
                  w_state_n    = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (bus.redirect_valid_i) begin
               w_pc_n    = bus.redirect_pc_i;
               w_state_n = S_REQ;
            end else if (bus.id_ready_i) begin
               w_pc_n    = r_pc + 64'd4;
               w_state_n = S_REQ;
            end
         end
         default: w_state_n = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_pc       <= RESET_PC;
         r_drop     <= 1'b0;
         r_inst     <= 32'h0;
         r_if_pc    <= 64'h0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_pc       <= w_pc_n;
         r_drop     <= w_drop_n;
         r_inst     <= w_inst_n;
         r_if_pc    <= w_if_pc_n;
         r_misalign <= w_misalign_n;
      end
   end
endmodule
